score_keeper: RTL and testbench

SCORE_KEEPER -- requirements
Module: score_keeper

---
 rtl/score_pkg.sv | 20 ++
 rtl/score_keeper_edge_detect.sv | 22 ++
 rtl/score_keeper.sv | 139 +++++++++++++
 tb/tb_score_keeper.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// Shared types and defaults for the score keeper: FSM state encoding,
// default win score / serve delay, and a saturating score increment.
package score_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SERVE_WAIT = 2'b01,
        PLAY       = 2'b10,
        OVER       = 2'b11
    } state_t;

    localparam logic [3:0] WIN_SCORE_DEFAULT    = 4'd10;
    localparam logic [7:0] SERVE_FRAMES_DEFAULT = 8'd60;

    // Scores stop at the limit instead of wrapping back to zero.
    function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
        return (score >= limit) ? limit : score + 4'd1;
    endfunction

endpackage

// File: rtl/score_keeper_edge_detect.sv
// Rising-edge detector for a level input: one-cycle rise while the level
// is high and its registered copy is still low.
module edge_detect (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic rise
);

    logic prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            prev <= 1'b0;
        end else begin
            prev <= level;
        end
    end

    assign rise = level & ~prev;

endmodule

// File: rtl/score_keeper.sv
// Pong score keeper: serve timing, goal scoring and win detection.
// Define SERVE_DELAY_EN to wait SERVE_FRAMES frame ticks before each serve.
module score_keeper
    import score_pkg::*;
#(
    parameter logic [3:0] WIN_SCORE    = WIN_SCORE_DEFAULT,
    parameter logic [7:0] SERVE_FRAMES = SERVE_FRAMES_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       inPlay,
    input  logic       newGame,
    input  logic       frame_tick,
    input  logic       goal_p0,
    input  logic       goal_p1,
    output logic [3:0] p0_score,
    output logic [3:0] p1_score,
    output logic       ball_en,
    output logic       serve,
    output logic       serve_dir
);

    state_t     state;
    logic       rise_p0;
    logic       rise_p1;
    logic       point_p0;
    logic       point_p1;
    logic [3:0] p0_next;
    logic [3:0] p1_next;
    logic       serve_due;

    edge_detect u_goal_p0 (
        .clock (clock),
        .reset (reset),
        .level (goal_p0),
        .rise  (rise_p0)
    );

    edge_detect u_goal_p1 (
        .clock (clock),
        .reset (reset),
        .level (goal_p1),
        .rise  (rise_p1)
    );

    // A tie (both edges in one cycle) awards nothing.
    assign point_p0 = inPlay & rise_p0 & ~rise_p1;
    assign point_p1 = inPlay & rise_p1 & ~rise_p0;
    assign p0_next  = sat_inc(p0_score, WIN_SCORE);
    assign p1_next  = sat_inc(p1_score, WIN_SCORE);

`ifdef SERVE_DELAY_EN
    logic [7:0] frame_cnt;

    // Serve on the tick that would bring the count up to SERVE_FRAMES.
    assign serve_due = inPlay & frame_tick & (frame_cnt == SERVE_FRAMES - 8'd1);
`else
    logic unused_cfg;

    assign serve_due  = inPlay;
    assign unused_cfg = frame_tick | (|SERVE_FRAMES);
`endif

    // NOTE: every register here uses <= so all of them sample the pre-edge
    // values; a blocking = would let later lines see already-updated state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            p0_score  <= 4'd0;
            p1_score  <= 4'd0;
            ball_en   <= 1'b0;
            serve     <= 1'b0;
            serve_dir <= 1'b0;
`ifdef SERVE_DELAY_EN
            frame_cnt <= 8'd0;
`endif
        end else begin
            serve <= 1'b0;
            if (newGame) begin
                state     <= IDLE;
                p0_score  <= 4'd0;
                p1_score  <= 4'd0;
                ball_en   <= 1'b0;
                serve_dir <= 1'b0;
`ifdef SERVE_DELAY_EN
                frame_cnt <= 8'd0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        ball_en <= 1'b0;
                        if (inPlay) begin
                            state     <= SERVE_WAIT;
                            serve_dir <= 1'b0;
                        end
                    end

                    SERVE_WAIT: begin
                        ball_en <= serve_due;
                        if (serve_due) begin
                            serve <= 1'b1;
                            state <= PLAY;
`ifdef SERVE_DELAY_EN
                            frame_cnt <= 8'd0;
                        end else if (inPlay && frame_tick) begin
                            frame_cnt <= frame_cnt + 8'd1;
`endif
                        end
                    end

                    PLAY: begin
                        ball_en <= inPlay;
                        if (point_p0) begin
                            p0_score  <= p0_next;
                            serve_dir <= 1'b1;
                            ball_en   <= 1'b0;
                            state     <= (p0_next == WIN_SCORE) ? OVER : SERVE_WAIT;
                        end else if (point_p1) begin
                            p1_score  <= p1_next;
                            serve_dir <= 1'b0;
                            ball_en   <= 1'b0;
                            state     <= (p1_next == WIN_SCORE) ? OVER : SERVE_WAIT;
                        end
                    end

                    OVER: begin
                        ball_en <= 1'b0;
                    end

                    default: begin
                        state   <= IDLE;
                        ball_en <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: directed scenarios plus a randomized
// run compared against a rule-level reference model.
module tb_score_keeper;

    localparam logic [3:0] WIN    = 4'd10;
    localparam logic [7:0] FRAMES = 8'd60;

`ifdef SERVE_DELAY_EN
    localparam bit DELAY      = 1'b1;
    localparam int OPEN_LAT   = int'(FRAMES) + 1;
    localparam int PRE_PAUSE  = 30;
    localparam int POST_PAUSE = 30;
`else
    localparam bit DELAY      = 1'b0;
    localparam int OPEN_LAT   = 2;
    localparam int PRE_PAUSE  = 0;
    localparam int POST_PAUSE = 1;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        inPlay = 1'b0;
    logic        newGame = 1'b0;
    logic        frame_tick = 1'b0;
    logic        goal_p0 = 1'b0;
    logic        goal_p1 = 1'b0;
    logic [3:0]  p0_score;
    logic [3:0]  p1_score;
    logic        ball_en;
    logic        serve;
    logic        serve_dir;
    logic [10:0] outs;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    assign outs = {p0_score, p1_score, ball_en, serve, serve_dir};

    score_keeper #(
        .WIN_SCORE    (WIN),
        .SERVE_FRAMES (FRAMES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .inPlay     (inPlay),
        .newGame    (newGame),
        .frame_tick (frame_tick),
        .goal_p0    (goal_p0),
        .goal_p1    (goal_p1),
        .p0_score   (p0_score),
        .p1_score   (p1_score),
        .ball_en    (ball_en),
        .serve      (serve),
        .serve_dir  (serve_dir)
    );

    // Reference model: game phases and scores as described by the game rules.
    typedef enum {PH_IDLE, PH_WAIT, PH_RALLY, PH_DONE} phase_t;
    phase_t ph = PH_IDLE;
    int     m_p0 = 0;
    int     m_p1 = 0;
    int     m_ticks = 0;
    bit     m_dir = 1'b0;
    bit     m_serve = 1'b0;
    bit     m_ball = 1'b0;
    bit     m_last0 = 1'b0;
    bit     m_last1 = 1'b0;

    task automatic launch();
        m_serve = 1'b1;
        m_ticks = 0;
        ph      = PH_RALLY;
        m_ball  = 1'b1;
    endtask

    task automatic model_edge(input bit rst, input bit ip, input bit ng, input bit ft,
                              input bit g0, input bit g1);
        bit new0 = g0 && !m_last0;
        bit new1 = g1 && !m_last1;
        m_last0 = rst ? 1'b0 : g0;
        m_last1 = rst ? 1'b0 : g1;
        m_serve = 1'b0;
        if (rst || ng) begin
            ph = PH_IDLE; m_p0 = 0; m_p1 = 0; m_ticks = 0; m_dir = 1'b0; m_ball = 1'b0;
        end else begin
            case (ph)
                PH_IDLE: begin
                    m_ball = 1'b0;
                    if (ip) begin ph = PH_WAIT; m_dir = 1'b0; end
                end
                PH_WAIT: begin
                    m_ball = 1'b0;
                    if (DELAY) begin
                        if (ip && ft) m_ticks = m_ticks + 1;
                        if (m_ticks == int'(FRAMES)) launch();
                    end else if (ip) begin
                        launch();
                    end
                end
                PH_RALLY: begin
                    m_ball = ip;
                    if (ip && new0 && !new1) begin
                        m_p0 = (m_p0 + 1 > int'(WIN)) ? int'(WIN) : m_p0 + 1;
                        m_dir = 1'b1; m_ball = 1'b0;
                        ph = (m_p0 == int'(WIN)) ? PH_DONE : PH_WAIT;
                    end else if (ip && new1 && !new0) begin
                        m_p1 = (m_p1 + 1 > int'(WIN)) ? int'(WIN) : m_p1 + 1;
                        m_dir = 1'b0; m_ball = 1'b0;
                        ph = (m_p1 == int'(WIN)) ? PH_DONE : PH_WAIT;
                    end
                end
                default: m_ball = 1'b0;
            endcase
        end
    endtask

    task automatic step(input bit rst, input bit ip, input bit ng, input bit ft,
                        input bit g0, input bit g1);
        reset = rst; inPlay = ip; newGame = ng; frame_tick = ft; goal_p0 = g0; goal_p1 = g1;
        @(posedge clock);
        model_edge(rst, ip, ng, ft, g0, g1);
        #1;
    endtask

    task automatic run_to_play(input string tag);
        int n = 0;
        if (ph == PH_RALLY) return;
        do begin
            step(0, 1, 0, 1, 0, 0);
            n++;
        end while (serve !== 1'b1 && n < 300);
        checks++;
        if (serve !== 1'b1) begin
            errors++;
            $display("FAIL %s_serve_timeout: no serve after %0d cycles, required one", tag, n);
        end
    endtask

    task automatic test_reset();
        step(1, 1, 1, 1, 1, 1);
        step(1, 1, 0, 1, 1, 0);
        checks++;
        if (outs !== 11'd0) begin
            errors++; $display("FAIL reset_outputs: got %b required %b", outs, 11'd0);
        end
        step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 0, 0);
        checks++;
        if (outs !== 11'd0) begin
            errors++; $display("FAIL idle_paused: got %b required %b", outs, 11'd0);
        end
    endtask

    task automatic test_opening_serve();
        int first = 0;
        int pulses = 0;
        for (int k = 1; k <= OPEN_LAT + 5; k++) begin
            step(0, 1, 0, 1, 0, 0);
            if (serve === 1'b1) begin
                pulses++;
                if (first == 0) first = k;
            end
        end
        checks++;
        if (first != OPEN_LAT) begin
            errors++; $display("FAIL open_serve_latency: got %0d required %0d", first, OPEN_LAT);
        end
        checks++;
        if (pulses != 1) begin
            errors++; $display("FAIL open_serve_pulses: got %0d required 1", pulses);
        end
        checks++;
        if (outs !== {4'd0, 4'd0, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL open_play_outputs: got %b required %b", outs, {4'd0, 4'd0, 3'b100});
        end
    endtask

    task automatic test_goal_hold();
        step(0, 1, 0, 0, 1, 0);
        checks++;
        if (outs !== {4'd1, 4'd0, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL goal_first_edge: got %b required %b", outs, {4'd1, 4'd0, 3'b001});
        end
        repeat (4) step(0, 1, 0, 0, 1, 0);
        checks++;
        if (p0_score !== 4'd1) begin
            errors++; $display("FAIL goal_held_once: got p0=%0d required 1", p0_score);
        end
        step(0, 1, 0, 0, 0, 0);
    endtask

    task automatic test_simultaneous();
        run_to_play("simul");
        step(0, 1, 0, 0, 1, 1);
        checks++;
        if ({p0_score, p1_score, ball_en} !== {4'd1, 4'd0, 1'b1}) begin
            errors++; $display("FAIL tie_ignored: got p0=%0d p1=%0d ball=%b required 1 0 1",
                               p0_score, p1_score, ball_en);
        end
        step(0, 1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 1);
        checks++;
        if ({p0_score, p1_score, ball_en, serve_dir} !== {4'd1, 4'd1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL p1_point_after_tie: got p0=%0d p1=%0d ball=%b dir=%b required 1 1 0 0",
                               p0_score, p1_score, ball_en, serve_dir);
        end
    endtask

    task automatic test_pause();
        int pulses = 0;
        int n = 0;
        for (int k = 0; k < PRE_PAUSE; k++) begin
            step(0, 1, 0, 1, 0, 0);
            if (serve === 1'b1) pulses++;
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 0, 1, 0, 0);
            if (serve === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || ball_en !== 1'b0) begin
            errors++; $display("FAIL pause_hold: got %0d serves ball=%b required 0 serves ball=0", pulses, ball_en);
        end
        do begin
            step(0, 1, 0, 1, 0, 0);
            n++;
        end while (serve !== 1'b1 && n < 200);
        checks++;
        if (n != POST_PAUSE) begin
            errors++; $display("FAIL pause_resume_serve: got %0d ticks required %0d", n, POST_PAUSE);
        end
    endtask

    task automatic test_win();
        int pulses = 0;
        int ball_hi = 0;
        for (int k = 0; k < 8; k++) begin
            step(0, 1, 0, 0, 1, 0);
            run_to_play("win");
        end
        checks++;
        if (p0_score !== 4'd9) begin
            errors++; $display("FAIL win_ramp: got p0=%0d required 9", p0_score);
        end
        step(0, 1, 0, 0, 1, 0);
        checks++;
        if (outs !== {4'd10, 4'd1, 1'b0, 1'b0, 1'b1}) begin
            errors++; $display("FAIL win_reached: got %b required %b", outs, {4'd10, 4'd1, 3'b001});
        end
        for (int k = 0; k < 80; k++) begin
            step(0, 1, 0, 1, k[0], k[1]);
            if (serve === 1'b1) pulses++;
            if (ball_en === 1'b1) ball_hi++;
        end
        checks++;
        if ({p0_score, p1_score} !== {4'd10, 4'd1} || pulses != 0 || ball_hi != 0) begin
            errors++; $display("FAIL over_hold: got p0=%0d p1=%0d serves=%0d ball_cycles=%0d required 10 1 0 0",
                               p0_score, p1_score, pulses, ball_hi);
        end
    endtask

    task automatic test_new_game();
        int n = 0;
        step(0, 1, 1, 1, 1, 1);
        checks++;
        if (outs !== 11'd0) begin
            errors++; $display("FAIL newgame_clear: got %b required %b", outs, 11'd0);
        end
        do begin
            step(0, 1, 0, 1, 0, 0);
            n++;
        end while (serve !== 1'b1 && n < 200);
        checks++;
        if (n != OPEN_LAT || serve_dir !== 1'b0) begin
            errors++; $display("FAIL newgame_serve: got %0d cycles dir=%b required %0d dir=0", n, serve_dir, OPEN_LAT);
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 0, 0, 1, 0);
        run_to_play("mid");
        step(1, 1, 1, 1, 0, 1);
        checks++;
        if (outs !== 11'd0) begin
            errors++; $display("FAIL reset_mid_game: got %b required %b", outs, 11'd0);
        end
        step(0, 0, 0, 1, 0, 1);
        checks++;
        if (outs !== 11'd0) begin
            errors++; $display("FAIL reset_then_idle: got %b required %b", outs, 11'd0);
        end
    endtask

    task automatic test_random();
        bit g0 = 1'b0;
        bit g1 = 1'b0;
        bit rst, ip, ng, ft;
        logic [10:0] expv;
        int shown = 0;
        step(1, 0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 8000; cyc++) begin
            rst = ($urandom_range(0, 1999) == 0);
            ng  = ($urandom_range(0, 999) == 0);
            ip  = ($urandom_range(0, 7) != 0);
            ft  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 5) == 0) g0 = ~g0;
            if ($urandom_range(0, 5) == 0) g1 = ~g1;
            step(rst, ip, ng, ft, g0, g1);
            expv = {m_p0[3:0], m_p1[3:0], m_ball, m_serve, m_dir};
            checks++;
            if (outs !== expv) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_cycle_%0d: got %b required %b (p0 p1 ball serve dir)", cyc, outs, expv);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_opening_serve();
        test_goal_hold();
        test_simultaneous();
        test_pause();
        test_win();
        test_new_game();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
